// File: rtl/hilo_pkg.sv
// hilo_pkg: shared op codes, FSM states and default width for the HI/LO register block.
package hilo_pkg;
  localparam int W_DEFAULT = 32;
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_WRITE = 3'd1,
    OP_MTHI  = 3'd2,
    OP_MTLO  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5,
    OP_RSVD  = 3'd6,
    OP_CLEAR = 3'd7
  } opT;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } stateT;
endpackage

// File: rtl/hilo_addsplit.sv
// hilo_addsplit: W-bit adder with carry in/out, one instance per half of the accumulator.
//   a, b  : W-bit addends
//   cin   : carry in
//   sum   : W-bit sum
//   cout  : carry out
module hilo_addsplit #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/hilo_acc_reg.sv
// hilo_acc_reg: architectural HI/LO pair with writes, moves, clear and two-cycle MADD/MSUB.
//   Clk      : clock, state updates on the falling edge
//   Reset    : asynchronous active-high reset
//   Op       : operation code, sampled when Valid && Ready
//   Valid    : producer presents Op and operands
//   Ready    : block is idle and can accept an Op
//   ResultHI : high half of product/quotient (WRITE, MADD, MSUB)
//   ResultLO : low half of product/quotient (WRITE, MADD, MSUB)
//   MoveData : rs operand for MTHI/MTLO
//   HIOut    : architectural HI
//   LOOut    : architectural LO
//   Busy     : accumulate in progress
//   debugOut : {HIOut, LOOut}
module hilo_acc_reg
  import hilo_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter bit ACC_EN = 1'b1
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [2:0]     Op,
  input  logic           Valid,
  output logic           Ready,
  input  logic [W-1:0]   ResultHI,
  input  logic [W-1:0]   ResultLO,
  input  logic [W-1:0]   MoveData,
  output logic [W-1:0]   HIOut,
  output logic [W-1:0]   LOOut,
  output logic           Busy,
  output logic [2*W-1:0] debugOut
);
  stateT state, stateNext;
  logic [W-1:0] hiReg, loReg, hiNext, loNext;
  logic [W-1:0] loLatch, hiOpLatch, loSum, hiSum, loOperand;
  logic carryLatch, loCarry, unusedHiCarry, isSub, accept, accOp;
  assign accept    = Valid && state == ST_IDLE;
  assign isSub     = opT'(Op) == OP_MSUB;
  assign accOp     = ACC_EN && (opT'(Op) == OP_MADD || opT'(Op) == OP_MSUB);
  // Subtraction is two's complement: invert the operand and inject +1 as carry-in.
  assign loOperand = isSub ? ~ResultLO : ResultLO;
  hilo_addsplit #(.W(W)) uLo (
    .a(loReg), .b(loOperand), .cin(isSub), .sum(loSum), .cout(loCarry)
  );
  // High half runs one cycle later from latched operands; its carry-out is the silent wrap.
  hilo_addsplit #(.W(W)) uHi (
    .a(hiReg), .b(hiOpLatch), .cin(carryLatch), .sum(hiSum), .cout(unusedHiCarry)
  );
  always_comb begin
    stateNext = state;
    hiNext    = hiReg;
    loNext    = loReg;
    if (state == ST_ACC) begin
      stateNext = ST_IDLE;
      hiNext    = hiSum;
      loNext    = loLatch;
    end else if (Valid) begin
      case (opT'(Op))
        OP_WRITE: begin
          hiNext = ResultHI;
          loNext = ResultLO;
        end
        OP_MTHI:  hiNext = MoveData;
        OP_MTLO:  loNext = MoveData;
        OP_CLEAR: begin
          hiNext = '0;
          loNext = '0;
        end
        default:  stateNext = accOp ? ST_ACC : ST_IDLE;
      endcase
    end
  end
  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      hiReg      <= '0;
      loReg      <= '0;
      loLatch    <= '0;
      hiOpLatch  <= '0;
      carryLatch <= 1'b0;
    end else begin
      state <= stateNext;
      hiReg <= hiNext;
      loReg <= loNext;
      if (accept && accOp) begin
        loLatch    <= loSum;
        carryLatch <= loCarry;
        hiOpLatch  <= isSub ? ~ResultHI : ResultHI;
      end
    end
  end
  assign Ready    = state == ST_IDLE;
  assign Busy     = state == ST_ACC;
  assign HIOut    = hiReg;
  assign LOOut    = loReg;
  assign debugOut = {hiReg, loReg};
endmodule
